// File: rtl/axis_pcie_rxs_arb_if.sv
// Multi-lane PCIe RX-streaming bundle: one tvalid/tdata/tlast/tuser lane per source.
// A single-lane instance (N=1) carries the merged stream.
interface axis_pcie_rxs_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned USER_W = 8
);
  logic [N-1:0]             tvalid;
  logic [N-1:0]             tlast;
  logic [N-1:0][DATA_W-1:0] tdata;
  logic [N-1:0][USER_W-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser);
  modport slave  (input  tvalid, input  tdata, input  tlast, input  tuser);
endinterface

// File: rtl/axis_pcie_rxs_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC RX-streaming sources into one
// registered output stream. A grant is held from the first beat until tlast.
module axis_pcie_rxs_arb #(
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned TREADY_RST_VAL = 0,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned USER_W         = 8,
  localparam int unsigned SRC_W         = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  axis_pcie_rxs_if.slave     s_if,
  output logic [NUM_SRC-1:0] s_if_tready,
  axis_pcie_rxs_if.master    m_if,
  input  logic               m_if_tready,
  output logic [SRC_W-1:0]   active_src,
  output logic               busy
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e              state_q, state_d;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [USER_W-1:0]   out_user_q, out_user_d;
  logic                out_last_q, out_last_d;
  logic [SRC_W-1:0]    lock_src_q, lock_src_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [SRC_W-1:0]    act_q, act_d;

  logic                can_load;
  logic                win_vld;
  logic [SRC_W-1:0]    win_idx;
  logic [SRC_W-1:0]    cand;
  logic [SRC_W-1:0]    grant;
  logic [NUM_SRC-1:0]  rdy;
  logic                xfer;
  int unsigned         pos;

  // State and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_user_q <= '0;
      out_last_q <= 1'b0;
      lock_src_q <= '0;
      ptr_q      <= '0;
      act_q      <= '0;
    end else begin
      state_q    <= state_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_user_q <= out_user_d;
      out_last_q <= out_last_d;
      lock_src_q <= lock_src_d;
      ptr_q      <= ptr_d;
      act_q      <= act_d;
    end
  end

  // Grant selection and per-source ready: rotating search from ptr, or the locked owner
  always_comb begin
    can_load = ~out_vld_q | m_if_tready;
    win_vld  = 1'b0;
    win_idx  = '0;
    cand     = '0;
    pos      = 0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NUM_SRC) pos = pos - NUM_SRC;
      cand = SRC_W'(pos);
      if (!win_vld && s_if.tvalid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    grant = (state_q == ST_LOCKED) ? lock_src_q : win_idx;
    rdy   = '0;
    if (state_q == ST_LOCKED || win_vld) rdy[grant] = can_load;
    xfer  = s_if.tvalid[grant] & rdy[grant];
  end

  // Next state: load on transfer, lock on non-last beat, advance ptr past the sender on tlast
  always_comb begin
    state_d    = state_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_user_d = out_user_q;
    out_last_d = out_last_q;
    lock_src_d = lock_src_q;
    ptr_d      = ptr_q;
    act_d      = act_q;
    if (xfer) begin
      out_vld_d  = 1'b1;
      out_data_d = s_if.tdata[grant];
      out_user_d = s_if.tuser[grant];
      out_last_d = s_if.tlast[grant];
      act_d      = grant;
      if (s_if.tlast[grant]) begin
        state_d = ST_IDLE;
        ptr_d   = (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + SRC_W'(1);
      end else begin
        state_d    = ST_LOCKED;
        lock_src_d = grant;
      end
    end else if (m_if_tready) begin
      out_vld_d = 1'b0;
    end
  end

  assign s_if_tready    = (TREADY_RST_VAL == 0 && !rst_n) ? '0 : rdy;
  assign m_if.tvalid[0] = out_vld_q;
  assign m_if.tdata[0]  = out_data_q;
  assign m_if.tuser[0]  = out_user_q;
  assign m_if.tlast[0]  = out_last_q;
  assign active_src     = act_q;
  assign busy           = (state_q == ST_LOCKED);

endmodule
